// File: rtl/reg_file_16x8.sv
// 16 x 8 register file serving the system controller's RF read/write
// commands. Reads return registered data with a one-cycle valid pulse;
// entries 0..3 are exported continuously to the ALU, UART and clock divider.
module reg_file_16x8 #(
    parameter int unsigned           WIDTH    = 8,
    parameter int unsigned           DEPTH    = 16,
    parameter int unsigned           ADDR     = 4,
    parameter logic [WIDTH-1:0]      REG2_RST = 8'h81,
    parameter logic [WIDTH-1:0]      REG3_RST = 8'h20
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             WrEn,
    input  logic             RdEn,
    input  logic [ADDR-1:0]  Address,
    input  logic [WIDTH-1:0] WrData,
    output logic [WIDTH-1:0] RdData,
    output logic             RdData_Valid,
    output logic [WIDTH-1:0] REG0,
    output logic [WIDTH-1:0] REG1,
    output logic [WIDTH-1:0] REG2,
    output logic [WIDTH-1:0] REG3
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Simultaneous strobes cancel each other: neither a write nor a read.
    logic wr_go;
    logic rd_go;

    // Qualify the strobes so a conflicting command is a no-op.
    always_comb begin
        wr_go = WrEn & ~RdEn;
        rd_go = RdEn & ~WrEn;
    end

    // Storage array: reset to defaults (UART config and divider ratio in 2/3),
    // otherwise written on a qualified write strobe.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            mem    <= '{default: '0};
            mem[2] <= REG2_RST;
            mem[3] <= REG3_RST;
        end else if (wr_go) begin
            mem[Address] <= WrData;
        end
    end

    // Registered read port: data held between reads, valid pulses per read.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            RdData       <= '0;
            RdData_Valid <= 1'b0;
        end else begin
            RdData_Valid <= rd_go;
            if (rd_go) begin
                RdData <= mem[Address];
            end
        end
    end

    // Direct views of the configuration/operand entries, no added latency.
    always_comb begin
        REG0 = mem[0];
        REG1 = mem[1];
        REG2 = mem[2];
        REG3 = mem[3];
    end

endmodule

// File: tb/tb_reg_file_16x8.sv
// Self-checking bench for reg_file_16x8. Expected read data is pushed to a
// scoreboard queue when a read is issued and popped when RdData_Valid shows.
module tb_reg_file_16x8;

    logic       CLK;
    logic       RST;
    logic       WrEn;
    logic       RdEn;
    logic [3:0] Address;
    logic [7:0] WrData;
    logic [7:0] RdData;
    logic       RdData_Valid;
    logic [7:0] REG0;
    logic [7:0] REG1;
    logic [7:0] REG2;
    logic [7:0] REG3;

    int unsigned checks;
    int unsigned passed;

    logic [7:0] model [16];
    logic [7:0] sb_q [$];

    reg_file_16x8 #(
        .WIDTH    (8),
        .DEPTH    (16),
        .ADDR     (4),
        .REG2_RST (8'h81),
        .REG3_RST (8'h20)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .WrEn         (WrEn),
        .RdEn         (RdEn),
        .Address      (Address),
        .WrData       (WrData),
        .RdData       (RdData),
        .RdData_Valid (RdData_Valid),
        .REG0         (REG0),
        .REG1         (REG1),
        .REG2         (REG2),
        .REG3         (REG3)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Scoreboard consumer: every valid cycle must match the oldest pending read.
    always @(negedge CLK) begin
        if (RdData_Valid) begin
            checks++;
            if (sb_q.size() == 0) begin
                $display("FAIL sb_unexpected_valid: got RdData=%h with no read pending", RdData);
            end else begin
                logic [7:0] exp_d;
                exp_d = sb_q.pop_front();
                if (RdData !== exp_d)
                    $display("FAIL sb_rddata: got %h expected %h", RdData, exp_d);
                else
                    passed++;
            end
        end
    end

    // Hard time limit so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic model_reset();
        for (int i = 0; i < 16; i++) model[i] = 8'h00;
        model[2] = 8'h81;
        model[3] = 8'h20;
    endtask

    // Each task starts and ends 1 time unit after a rising edge.
    task automatic do_write(input logic [3:0] a, input logic [7:0] d);
        WrEn = 1'b1; RdEn = 1'b0; Address = a; WrData = d;
        @(posedge CLK); #1;
        WrEn = 1'b0;
        model[a] = d;
    endtask

    task automatic do_read(input logic [3:0] a);
        RdEn = 1'b1; WrEn = 1'b0; Address = a;
        sb_q.push_back(model[a]);
        @(posedge CLK); #1;
        RdEn = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_reset();
        do_write(4'd4, 8'h77);
        do_write(4'd0, 8'hA1);
        do_write(4'd1, 8'hB2);
        do_write(4'd2, 8'hC3);
        do_write(4'd3, 8'hD4);
        RdEn = 1'b1; Address = 4'd4;
        @(posedge CLK); #1;
        RdEn = 1'b0;
        checks++;
        if (RdData !== 8'h77 || RdData_Valid !== 1'b1)
            $display("FAIL pre_reset_read: got %h/%b expected 77/1", RdData, RdData_Valid);
        else
            passed++;
        #1 RST = 1'b0;
        sb_q.delete();
        model_reset();
        #1;
        checks++;
        if ({REG0, REG1, REG2, REG3} !== 32'h0000_8120)
            $display("FAIL reset_regs: got %h expected 00008120", {REG0, REG1, REG2, REG3});
        else
            passed++;
        checks++;
        if (RdData !== 8'h00 || RdData_Valid !== 1'b0)
            $display("FAIL reset_rd: got %h/%b expected 00/0", RdData, RdData_Valid);
        else
            passed++;
        @(posedge CLK); #4;
        RST = 1'b1;
        @(posedge CLK); #1;
        for (int a = 4; a < 16; a++) do_read(4'(a));
        idle(2);
        checks++;
        if (RdData !== 8'h00)
            $display("FAIL reset_gp_last: got %h expected 00", RdData);
        else
            passed++;
    endtask

    task automatic test_write_read();
        do_write(4'd7, 8'h5A);
        checks++;
        if (RdData_Valid !== 1'b0)
            $display("FAIL wr_no_valid: got %b expected 0", RdData_Valid);
        else
            passed++;
        do_read(4'd7);
        checks++;
        if (RdData !== 8'h5A || RdData_Valid !== 1'b1)
            $display("FAIL rd_latency: got %h/%b expected 5A/1", RdData, RdData_Valid);
        else
            passed++;
        idle(1);
        checks++;
        if (RdData_Valid !== 1'b0 || RdData !== 8'h5A)
            $display("FAIL rd_single_pulse: got %h/%b expected 5A/0", RdData, RdData_Valid);
        else
            passed++;
        do_write(4'd15, 8'hE7);
        do_read(4'd15);
        idle(1);
    endtask

    task automatic test_export();
        do_write(4'd0, 8'h12);
        checks++;
        if (REG0 !== 8'h12)
            $display("FAIL export_reg0: got %h expected 12", REG0);
        else
            passed++;
        do_write(4'd1, 8'h34);
        checks++;
        if (REG1 !== 8'h34 || REG0 !== 8'h12)
            $display("FAIL export_reg1: got %h/%h expected 34/12", REG1, REG0);
        else
            passed++;
        do_write(4'd3, 8'h40);
        checks++;
        if (REG3 !== 8'h40 || REG2 !== 8'h81)
            $display("FAIL export_reg3: got %h/%h expected 40/81", REG3, REG2);
        else
            passed++;
    endtask

    task automatic test_conflict();
        do_read(4'd1);
        idle(1);
        WrEn = 1'b1; RdEn = 1'b1; Address = 4'd2; WrData = 8'hFF;
        @(posedge CLK); #1;
        WrEn = 1'b0; RdEn = 1'b0;
        checks++;
        if (REG2 !== 8'h81 || RdData_Valid !== 1'b0 || RdData !== 8'h34)
            $display("FAIL conflict: got reg2=%h valid=%b rd=%h expected 81/0/34",
                     REG2, RdData_Valid, RdData);
        else
            passed++;
        do_read(4'd2);
        idle(1);
    endtask

    task automatic test_back_to_back();
        logic [3:0] addrs [3];
        logic [7:0] exps  [3];
        addrs[0] = 4'd0; addrs[1] = 4'd1; addrs[2] = 4'd3;
        exps[0]  = 8'h12; exps[1] = 8'h34; exps[2] = 8'h40;
        RdEn = 1'b1; WrEn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            Address = addrs[i];
            sb_q.push_back(model[addrs[i]]);
            @(posedge CLK); #1;
            checks++;
            if (RdData_Valid !== 1'b1 || RdData !== exps[i])
                $display("FAIL held_read_%0d: got %h/%b expected %h/1",
                         i, RdData, RdData_Valid, exps[i]);
            else
                passed++;
        end
        RdEn = 1'b0;
        idle(1);
        checks++;
        if (RdData_Valid !== 1'b0 || RdData !== 8'h40)
            $display("FAIL held_read_end: got %h/%b expected 40/0", RdData, RdData_Valid);
        else
            passed++;
    endtask

    task automatic test_reset_mid_write();
        WrEn = 1'b1; RdEn = 1'b0; Address = 4'd5; WrData = 8'hAA;
        #2 RST = 1'b0;
        sb_q.delete();
        model_reset();
        @(posedge CLK); #1;
        WrEn = 1'b0;
        #2 RST = 1'b1;
        @(posedge CLK); #1;
        checks++;
        if (REG0 !== 8'h00 || REG2 !== 8'h81)
            $display("FAIL mid_write_regs: got %h/%h expected 00/81", REG0, REG2);
        else
            passed++;
        do_read(4'd5);
        checks++;
        if (RdData !== 8'h00 || RdData_Valid !== 1'b1)
            $display("FAIL mid_write_discard: got %h/%b expected 00/1", RdData, RdData_Valid);
        else
            passed++;
        idle(1);
    endtask

    initial begin
        checks = 0;
        passed = 0;
        RST = 1'b0; WrEn = 1'b0; RdEn = 1'b0; Address = '0; WrData = '0;
        model_reset();
        #12 RST = 1'b1;
        @(posedge CLK); #1;

        test_reset();
        test_write_read();
        test_export();
        test_conflict();
        test_back_to_back();
        test_reset_mid_write();

        idle(2);
        checks++;
        if (sb_q.size() != 0)
            $display("FAIL sb_drain: %0d reads never returned, expected 0", sb_q.size());
        else
            passed++;

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
